// File: rtl/fb_pkg.sv
// Shared types and constants for the frame-buffer write path.
//   FB_WIDTH/FB_HEIGHT/FB_SIZE : frame geometry (160x120 = 19200 pixels)
//   ADDR_W/COLOUR_W            : pixel address and colour widths
//   fb_sched_state_t           : write scheduler FSM states
//   fb_grant_t                 : round-robin memory of the last accepted requester
//   fb_write_t                 : one frame-buffer write beat (enable, address, colour)
package fb_pkg;

    localparam int unsigned FB_WIDTH  = 160;
    localparam int unsigned FB_HEIGHT = 120;
    localparam int unsigned FB_SIZE   = FB_WIDTH * FB_HEIGHT;
    localparam int unsigned ADDR_W    = 15;
    localparam int unsigned COLOUR_W  = 12;

    typedef logic [ADDR_W-1:0]   fb_addr_t;
    typedef logic [COLOUR_W-1:0] fb_colour_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } fb_sched_state_t;

    typedef enum logic {
        GRANT_DRAW = 1'b0,
        GRANT_UI   = 1'b1
    } fb_grant_t;

    typedef struct packed {
        logic       we;
        fb_addr_t   addr;
        fb_colour_t colour;
    } fb_write_t;

endpackage

// File: rtl/fb_clear_sweep.sv
// Address counter for the full-frame clear sweep.
//   clk, reset : system clock, synchronous active-high reset
//   start      : restart the sweep at position 0
//   run        : advance one position (saturates at SIZE-1)
//   pos        : current sweep position
//   last       : pos is the final address SIZE-1
module fb_clear_sweep
    import fb_pkg::*;
#(
    parameter int unsigned SIZE = FB_SIZE
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     start,
    input  logic     run,
    output fb_addr_t pos,
    output logic     last
);

    localparam fb_addr_t LAST_POS = fb_addr_t'(SIZE - 1);

    // Saturating counter; never steps past the final address.
    always_ff @(posedge clk) begin
        if (reset) begin
            pos <= '0;
        end else if (start) begin
            pos <= '0;
        end else if (run && (pos != LAST_POS)) begin
            pos <= pos + fb_addr_t'(1);
        end
    end

    assign last = (pos == LAST_POS);

endmodule

// File: rtl/fb_write_scheduler.sv
// Owner of the frame-buffer write port: arbitrates draw and ui writers
// round-robin and runs full-frame clear sweeps.
//   clk, reset                       : system clock, synchronous active-high reset
//   clear_req                        : level request for a full-frame clear (sampled in IDLE)
//   clear_busy                       : high alongside every sweep write on fb_we
//   clear_done                       : one-cycle pulse after the last sweep write
//   draw_valid/ready/addr/colour     : draw engine write handshake
//   ui_valid/ready/addr/colour       : ui overlay write handshake
//   fb_we, fb_addr, fb_wdata         : registered frame-buffer write port
module fb_write_scheduler
    import fb_pkg::*;
#(
    parameter int unsigned WIDTH        = FB_WIDTH,
    parameter int unsigned HEIGHT       = FB_HEIGHT,
    parameter fb_colour_t  CLEAR_COLOUR = 12'hFFF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear_req,
    output logic       clear_busy,
    output logic       clear_done,
    input  logic       draw_valid,
    output logic       draw_ready,
    input  fb_addr_t   draw_addr,
    input  fb_colour_t draw_colour,
    input  logic       ui_valid,
    output logic       ui_ready,
    input  fb_addr_t   ui_addr,
    input  fb_colour_t ui_colour,
    output logic       fb_we,
    output fb_addr_t   fb_addr,
    output fb_colour_t fb_wdata
);

    localparam int unsigned MEM_SIZE  = WIDTH * HEIGHT;
    localparam fb_addr_t    MEM_LIMIT = fb_addr_t'(MEM_SIZE);

    fb_sched_state_t state, state_n;
    fb_grant_t       last_grant, last_grant_n;
    fb_write_t       wr_n;
    logic            busy_n;
    logic            done_n;
    logic            sweep_start;
    logic            sweep_run;
    logic            sweep_last;
    fb_addr_t        sweep_pos;
    logic            draw_grant;
    logic            ui_grant;

    fb_clear_sweep #(
        .SIZE (MEM_SIZE)
    ) u_sweep (
        .clk   (clk),
        .reset (reset),
        .start (sweep_start),
        .run   (sweep_run),
        .pos   (sweep_pos),
        .last  (sweep_last)
    );

    // Round-robin: a lone requester always wins; on contention the one not
    // granted last time wins. The two grants are mutually exclusive.
    always_comb begin
        draw_grant = draw_valid && (!ui_valid || (last_grant == GRANT_UI));
        ui_grant   = ui_valid && (!draw_valid || (last_grant == GRANT_DRAW));
    end

    // Next-state, handshake and next write beat. The write issued here lands
    // on the registered fb_* port one cycle later, so the sweep issues
    // address 0 from IDLE and pos+1 from CLEAR; CLEAR ends once pos has
    // reached the last address (that write is then already on the port).
    always_comb begin
        state_n      = state;
        last_grant_n = last_grant;
        wr_n.we      = 1'b0;
        wr_n.addr    = fb_addr;
        wr_n.colour  = fb_wdata;
        busy_n       = 1'b0;
        done_n       = 1'b0;
        sweep_start  = 1'b0;
        sweep_run    = 1'b0;
        draw_ready   = 1'b0;
        ui_ready     = 1'b0;

        unique case (state)
            IDLE: begin
                if (clear_req) begin
                    state_n     = CLEAR;
                    sweep_start = 1'b1;
                    busy_n      = 1'b1;
                    wr_n.we     = 1'b1;
                    wr_n.addr   = '0;
                    wr_n.colour = CLEAR_COLOUR;
                end else begin
                    draw_ready = draw_grant;
                    ui_ready   = ui_grant;
                    // Out-of-range addresses complete the handshake but are dropped.
                    if (draw_grant) begin
                        last_grant_n = GRANT_DRAW;
                        if (draw_addr < MEM_LIMIT) begin
                            wr_n.we     = 1'b1;
                            wr_n.addr   = draw_addr;
                            wr_n.colour = draw_colour;
                        end
                    end else if (ui_grant) begin
                        last_grant_n = GRANT_UI;
                        if (ui_addr < MEM_LIMIT) begin
                            wr_n.we     = 1'b1;
                            wr_n.addr   = ui_addr;
                            wr_n.colour = ui_colour;
                        end
                    end
                end
            end

            CLEAR: begin
                if (sweep_last) begin
                    state_n = DONE;
                    done_n  = 1'b1;
                end else begin
                    sweep_run   = 1'b1;
                    busy_n      = 1'b1;
                    wr_n.we     = 1'b1;
                    wr_n.addr   = sweep_pos + fb_addr_t'(1);
                    wr_n.colour = CLEAR_COLOUR;
                end
            end

            DONE: begin
                state_n = IDLE;
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= GRANT_UI;
            fb_we      <= 1'b0;
            fb_addr    <= '0;
            fb_wdata   <= '0;
            clear_busy <= 1'b0;
            clear_done <= 1'b0;
        end else begin
            state      <= state_n;
            last_grant <= last_grant_n;
            fb_we      <= wr_n.we;
            fb_addr    <= wr_n.addr;
            fb_wdata   <= wr_n.colour;
            clear_busy <= busy_n;
            clear_done <= done_n;
        end
    end

endmodule

// File: tb/tb_fb_write_scheduler.sv
// Scoreboard bench for fb_write_scheduler: the driver pushes expected
// frame-buffer writes as it sees handshakes / clear starts, and a negedge
// monitor pops and compares every fb_we beat and every clear_done pulse.
module tb_fb_write_scheduler;

    localparam int MEM_SIZE = 19200;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clear_req = 1'b0;
    logic        clear_busy;
    logic        clear_done;
    logic        draw_valid = 1'b0;
    logic        draw_ready;
    logic [14:0] draw_addr = '0;
    logic [11:0] draw_colour = '0;
    logic        ui_valid = 1'b0;
    logic        ui_ready;
    logic [14:0] ui_addr = '0;
    logic [11:0] ui_colour = '0;
    logic        fb_we;
    logic [14:0] fb_addr;
    logic [11:0] fb_wdata;

    fb_write_scheduler dut (
        .clk         (clk),
        .reset       (reset),
        .clear_req   (clear_req),
        .clear_busy  (clear_busy),
        .clear_done  (clear_done),
        .draw_valid  (draw_valid),
        .draw_ready  (draw_ready),
        .draw_addr   (draw_addr),
        .draw_colour (draw_colour),
        .ui_valid    (ui_valid),
        .ui_ready    (ui_ready),
        .ui_addr     (ui_addr),
        .ui_colour   (ui_colour),
        .fb_we       (fb_we),
        .fb_addr     (fb_addr),
        .fb_wdata    (fb_wdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [14:0] addr;
        logic [11:0] col;
        logic        busy;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass = 0;
    int   done_seen = 0;
    int   exp_done_cyc = -1;
    logic mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic push_write(input logic [14:0] a, input logic [11:0] c, input logic b);
        exp_t e;
        e.addr = a;
        e.col  = c;
        e.busy = b;
        exp_q.push_back(e);
    endtask

    task automatic push_sweep();
        for (int a = 0; a < MEM_SIZE; a++) push_write(15'(a), 12'hFFF, 1'b1);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every fb_we beat must match the head of the expected queue.
    always @(negedge clk) begin
        if (mon_en && !reset) begin
            if (fb_we) begin
                check("addr_in_range", 32'(fb_addr < 15'd19200), 32'd1);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write (cycle %0d)",
                             fb_addr, fb_wdata, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("write{busy,addr,data}", {4'd0, clear_busy, fb_addr, fb_wdata},
                          {4'd0, mon_e.busy, mon_e.addr, mon_e.col});
                end
            end else begin
                check("busy_without_write", 32'(clear_busy), 32'd0);
            end
            if (clear_done) begin
                done_seen++;
                check("done_cycle", 32'(cyc), 32'(exp_done_cyc));
                check("done_we", 32'(fb_we), 32'd0);
            end
        end
    end

    localparam logic [3:0] RR_DRAW = 4'b0101;  // bit i: draw wins contested cycle i

    initial begin
        int bad;

        // 1: reset and idle
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        mon_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 0) begin
                check("rst_fb_addr", 32'(fb_addr), 32'd0);
                check("rst_fb_wdata", 32'(fb_wdata), 32'd0);
            end
            check("idle_we", 32'(fb_we), 32'd0);
            check("idle_done", 32'(clear_done), 32'd0);
            check("idle_readys", {30'd0, draw_ready, ui_ready}, 32'd0);
        end
        step();

        // 3: contested round-robin straight after reset: D,U,D,U
        draw_valid = 1'b1; draw_addr = 15'h10; draw_colour = 12'h0F0;
        ui_valid = 1'b1;   ui_addr = 15'h20;   ui_colour = 12'h00F;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rr_grant{d,u}", {30'd0, draw_ready, ui_ready}, {30'd0, RR_DRAW[i], ~RR_DRAW[i]});
            if (RR_DRAW[i]) push_write(15'h10, 12'h0F0, 1'b0);
            else            push_write(15'h20, 12'h00F, 1'b0);
            step();
        end
        draw_valid = 1'b0;
        ui_valid = 1'b0;

        // 2: lone draw write
        draw_valid = 1'b1; draw_addr = 15'h0123; draw_colour = 12'hF00;
        @(negedge clk);
        check("draw_only{d,u}", {30'd0, draw_ready, ui_ready}, 32'd2);
        push_write(15'h0123, 12'hF00, 1'b0);
        step();
        draw_valid = 1'b0;

        // lone ui write
        ui_valid = 1'b1; ui_addr = 15'h0200; ui_colour = 12'h0AB;
        @(negedge clk);
        check("ui_only{d,u}", {30'd0, draw_ready, ui_ready}, 32'd1);
        push_write(15'h0200, 12'h0AB, 1'b0);
        step();
        ui_valid = 1'b0;
        repeat (2) step();

        // 4: clear beats a pending draw write
        clear_req = 1'b1;
        draw_valid = 1'b1; draw_addr = 15'h0055; draw_colour = 12'h5A5;
        @(negedge clk);
        check("clear_beats_draw{d,u}", {30'd0, draw_ready, ui_ready}, 32'd0);
        push_sweep();
        exp_done_cyc = cyc + 1 + MEM_SIZE;
        step();
        clear_req = 1'b0;
        bad = 0;
        for (int i = 0; i < MEM_SIZE + 1; i++) begin
            @(negedge clk);
            if (draw_ready || ui_ready) bad++;
        end
        check("readys_low_during_clear", 32'(bad), 32'd0);
        @(negedge clk);
        check("ready_after_done", 32'(draw_ready), 32'd1);
        push_write(15'h0055, 12'h5A5, 1'b0);
        step();
        draw_valid = 1'b0;
        repeat (2) step();
        check("sweep1_drained", 32'(exp_q.size()), 32'd0);

        // 5: clear_req pulse mid-sweep is ignored
        clear_req = 1'b1;
        @(negedge clk);
        push_sweep();
        exp_done_cyc = cyc + 1 + MEM_SIZE;
        step();
        clear_req = 1'b0;
        repeat (4999) @(posedge clk);
        #1 clear_req = 1'b1;
        @(negedge clk);
        check("midsweep_readys", {30'd0, draw_ready, ui_ready}, 32'd0);
        step();
        clear_req = 1'b0;
        while (cyc < exp_done_cyc + 3) @(posedge clk);
        #1;
        check("sweep2_drained", 32'(exp_q.size()), 32'd0);

        // 6: reset mid-sweep aborts, then out-of-range write is dropped
        exp_done_cyc = -1;
        clear_req = 1'b1;
        @(negedge clk);
        push_sweep();
        step();
        clear_req = 1'b0;
        repeat (99) @(posedge clk);
        #1 reset = 1'b1;
        exp_q.delete();
        step();
        reset = 1'b0;
        @(negedge clk);
        check("reset_abort_we", 32'(fb_we), 32'd0);
        check("reset_abort_busy", 32'(clear_busy), 32'd0);
        step();
        repeat (3) step();
        draw_valid = 1'b1; draw_addr = 15'd19200; draw_colour = 12'h123;
        @(negedge clk);
        check("oob_draw_ready", 32'(draw_ready), 32'd1);
        step();
        draw_valid = 1'b0;
        @(negedge clk);
        check("oob_dropped_we", 32'(fb_we), 32'd0);
        repeat (5) step();

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        check("done_count", 32'(done_seen), 32'd2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
